// File: rtl/fifo_downsize_pkg.sv
// Shared constants and types for the 32-bit-in / 4-bit-out FIFO.
package fifo_downsize_pkg;
  localparam int WR_WIDTH = 32;
  localparam int RD_WIDTH = 4;
  localparam int DEPTH    = 4;
  localparam int RATIO    = WR_WIDTH / RD_WIDTH;
  localparam int AW       = $clog2(DEPTH);
  localparam int IW       = $clog2(RATIO);
  localparam int LVL_W    = $clog2(DEPTH * RATIO + 1);

  // Valid nibble count of a stored word, 1..8.
  typedef logic [3:0] nib_cnt_t;

  // The write port encodes "all 8 nibbles" as 0.
  function automatic nib_cnt_t decode_cnt(input logic [2:0] c);
    return (c == 3'd0) ? nib_cnt_t'(RATIO) : {1'b0, c};
  endfunction
endpackage

// File: rtl/fifo_downsize_if.sv
// Write/read bus of the downsizing FIFO: the master drives requests, the slave is the FIFO.
interface fifo_downsize_if;
  import fifo_downsize_pkg::*;

  // wr is accepted at the next edge only while full is low; rd is serviced in the
  // same cycle only while empty is low, and rd_data_vld marks that service.
  logic                wr;
  logic [WR_WIDTH-1:0] wr_data;
  logic [2:0]          wr_nib_cnt;
  logic                full;
  logic                rd;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_data_vld;
  logic                rd_last;
  logic                empty;
  logic [LVL_W-1:0]    level;
  logic                ovf_err;
  logic                unf_err;

  modport master (
    output wr, wr_data, wr_nib_cnt, rd,
    input  full, rd_data, rd_data_vld, rd_last, empty, level, ovf_err, unf_err
  );

  modport slave (
    input  wr, wr_data, wr_nib_cnt, rd,
    output full, rd_data, rd_data_vld, rd_last, empty, level, ovf_err, unf_err
  );
endinterface

// File: rtl/fifo_downsize_ptr_ctl.sv
// Word pointer with an extra wrap bit; the address part wraps 3->0 and toggles the wrap bit.
module fifo_downsize_ptr_ctl
  import fifo_downsize_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_downsize.sv
// Asymmetric FIFO: 32-bit (possibly partial) words in, one 4-bit nibble out per read, LSB first.
module fifo_downsize
  import fifo_downsize_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fifo_downsize_if.slave bus
);

  logic [WR_WIDTH-1:0] mem     [DEPTH];
  nib_cnt_t            cnt_mem [DEPTH];

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [IW-1:0]    nib_idx;
  logic [LVL_W-1:0] level_q;
  logic             ovf_q;
  logic             unf_q;

  logic                wr_acc;
  logic                rd_acc;
  logic                addr_eq;
  logic                at_last;
  nib_cnt_t            wr_cnt;
  nib_cnt_t            cur_cnt;
  logic [WR_WIDTH-1:0] cur_word;

  assign addr_eq   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.full  = addr_eq && (wr_ptr[AW] != rd_ptr[AW]);
  assign bus.empty = addr_eq && (wr_ptr[AW] == rd_ptr[AW]);

  assign wr_acc   = bus.wr && !bus.full;
  assign rd_acc   = bus.rd && !bus.empty;
  assign wr_cnt   = decode_cnt(bus.wr_nib_cnt);
  assign cur_word = mem[rd_ptr[AW-1:0]];
  assign cur_cnt  = cnt_mem[rd_ptr[AW-1:0]];
  assign at_last  = ({1'b0, nib_idx} == (cur_cnt - 4'd1));

  // Output is forced to zero unless a nibble is actually being handed over.
  assign bus.rd_data     = rd_acc ? cur_word[nib_idx*RD_WIDTH +: RD_WIDTH] : '0;
  assign bus.rd_data_vld = rd_acc;
  assign bus.rd_last     = rd_acc && at_last;
  assign bus.level       = level_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

  fifo_downsize_ptr_ctl u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_downsize_ptr_ctl u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc && at_last),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]]     <= bus.wr_data;
      cnt_mem[wr_ptr[AW-1:0]] <= wr_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_idx <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (rd_acc) begin
        nib_idx <= at_last ? '0 : nib_idx + 1'b1;
      end
      level_q <= level_q + (wr_acc ? LVL_W'(wr_cnt) : '0) - (rd_acc ? LVL_W'(1) : '0);
      if (bus.wr && bus.full) begin
        ovf_q <= 1'b1;
      end
      if (bus.rd && bus.empty) begin
        unf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_downsize.sv
// Bench for fifo_downsize: directed and random traffic against a nibble-queue reference model.
module tb_fifo_downsize;
  import fifo_downsize_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_downsize_if bus ();

  fifo_downsize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every stored nibble as {last, nibble}, in read order.
  logic [4:0] exp_q[$];
  logic       m_ovf;
  logic       m_unf;

  function automatic int model_words();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][4]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare before the rising edge, advance the model.
  task automatic step(input logic w, input logic [31:0] d, input logic [2:0] c, input logic r);
    logic m_full, m_empty, wa, ra;
    int   n;
    bus.wr = w; bus.wr_data = d; bus.wr_nib_cnt = c; bus.rd = r;
    #1;
    m_full  = (model_words() == DEPTH);
    m_empty = (exp_q.size() == 0);
    wa = w && !m_full;
    ra = r && !m_empty;
    check("empty", bus.empty, m_empty);
    check("full", bus.full, m_full);
    check("level", bus.level, exp_q.size());
    check("ovf_err", bus.ovf_err, m_ovf);
    check("unf_err", bus.unf_err, m_unf);
    check("rd_data_vld", bus.rd_data_vld, ra);
    check("rd_data", bus.rd_data, ra ? exp_q[0][3:0] : 4'h0);
    check("rd_last", bus.rd_last, ra ? exp_q[0][4] : 1'b0);
    if (ra) void'(exp_q.pop_front());
    if (wa) begin
      n = (c == 3'd0) ? 8 : int'(c);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), d[i*4 +: 4]});
    end
    if (w && m_full) m_ovf = 1'b1;
    if (r && m_empty) m_unf = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.wr_data = '0; bus.wr_nib_cnt = '0;
    #1;
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_level", bus.level, 0);
    check("rst_ovf", bus.ovf_err, 1'b0);
    check("rst_unf", bus.unf_err, 1'b0);
    check("rst_rd_data", bus.rd_data, 0);
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int written;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.wr_data = '0; bus.wr_nib_cnt = '0;
    @(negedge clk);
    do_reset();

    // full word, nibbles 1..8
    step(1'b1, 32'h8765_4321, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // partial word of 3 nibbles
    step(1'b1, 32'h0000_0ABC, 3'd3, 1'b0);
    check("partial_level", bus.level, 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // fill to 4 words, then one dropped write
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 3'd0, 1'b0);
    check("fill_level", bus.level, 32);
    step(1'b1, $urandom, 3'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1);

    // 10 words streamed while reading every cycle; also one explicit write+read cycle
    do_reset();
    step(1'b1, 32'hCAFE_F00D, 3'd0, 1'b0);
    step(1'b1, 32'h0012_3456, 3'd5, 1'b1);
    check("wr_rd_level", bus.level, 8 + 5 - 1);
    written = 2;
    for (int i = 0; i < 300 && written < 12; i++) begin
      if (model_words() < DEPTH) begin
        step(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b1);
        written++;
      end else begin
        step(1'b0, '0, '0, 1'b1);
      end
    end
    check("stream_written", written, 12);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // underflow
    do_reset();
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // reset after 3 of 8 nibbles, then a fresh word reads from nibble 0
    do_reset();
    step(1'b1, 32'hFEDC_BA98, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    do_reset();
    step(1'b1, 32'h1357_9BDF, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 35), $urandom, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
